execute_cycle_cc: RTL and testbench
===================================

EXECUTE_CYCLE_CC -- requirements
Module: Execute_Cycle_CC

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock, all state on rising edge.
REQ-002 The block SHALL have these ports: rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 The block SHALL have these inputs: RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, MulE  in  1 each  ID/EX control.
REQ-004 The block SHALL have these inputs: ALUControlE[2:0] (ALU op), ForwardAE[1:0] and ForwardBE[1:0] (forward selects), RDE[4:0] (dest reg).
REQ-005 The block SHALL have these inputs: RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW  in  32 each.
REQ-006 The block SHALL have these outputs to the memory stage: RegWriteM, ResultSrcM, MemWriteM (1 each), RDM[4:0], ALUResultM[31:0], WriteDataM[31:0], all registered.
REQ-007 The block SHALL have these combinational outputs: PCSrcE (1, take branch/jump), PCTargetE (32), StallE (1, hold IF/ID/EX).

Function
REQ-008 SrcAE SHALL be RD1E, ResultW or ALUResultM for ForwardAE 00/01/10; 11 SHALL select RD1E.
REQ-009 WriteDataE SHALL be RD2E/ResultW/ALUResultM for ForwardBE 00/01/10 (11→RD2E); SrcBE SHALL be ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-010 The ALU SHALL implement 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 0/1); other codes SHALL yield 0; arithmetic SHALL wrap modulo 2^32.
REQ-011 ZeroE SHALL be 1 when the ALU result equals 0; PCSrcE SHALL be (BranchE&ZeroE)|JumpE; PCTargetE SHALL be PCE+ImmExtE, modulo 2^32.
REQ-012 When JumpE=1, the value captured into ALUResultM SHALL be PCPlus4E instead of the ALU result.
REQ-013 The multiply unit SHALL have an FSM with states IDLE, BUSY, DONE and SHALL compute the low 32 bits of SrcAE*WriteDataE by shift-add, one bit per cycle.
REQ-014 In IDLE with MulE=0, StallE SHALL be 0 and EX/MEM SHALL capture the ALU path every cycle (single-cycle latency).
REQ-015 In IDLE with MulE=1, the FSM SHALL latch both forwarded operands, RDE and RegWriteE, clear the accumulator, load a 6-bit counter with 32, and go to BUSY.
REQ-016 In BUSY, the FSM SHALL decrement the counter each cycle and go to DONE when the counter reaches 0 (exactly 32 BUSY cycles).
REQ-017 In DONE, the FSM SHALL return to IDLE, and EX/MEM SHALL capture the product, latched RDM and RegWriteM, with MemWriteM=0 and ResultSrcM=0.
REQ-018 StallE SHALL be 1 in the IDLE-with-MulE cycle and in every BUSY cycle, and 0 in DONE, so StallE is high for exactly 33 cycles.
REQ-019 While StallE=1, EX/MEM SHALL capture a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, RDM=0, ALUResultM=0, WriteDataM=0.
REQ-020 Forwarded inputs SHALL be ignored in BUSY and DONE; only the latched operands SHALL be used.
REQ-021 MulE asserted together with BranchE or JumpE SHALL force PCSrcE=0.
REQ-022 PCSrcE SHALL be forced to 0 while StallE=1.

Reset
REQ-023 While rst=0, all EX/MEM outputs SHALL be 0, the FSM SHALL be in IDLE, the counter and accumulator SHALL be 0, and StallE SHALL be 0, independent of clk.
REQ-024 A reset asserted during BUSY SHALL abort the multiply with no EX/MEM write, and the first edge after release SHALL act as IDLE.

Verification
REQ-025 The bench SHALL cover: RD1E=5, ImmExtE=7, ALUSrcE=1, ALUControlE=000, RDE=3, RegWriteE=1 → next edge ALUResultM=12, RDM=3, RegWriteM=1, StallE=0.
REQ-026 The bench SHALL cover: ForwardAE=10 with ALUResultM=0x10, ForwardBE=01 with ResultW=0x4, ALUControlE=001 → ALUResultM=0xC, WriteDataM=0x4.
REQ-027 The bench SHALL cover: BranchE=1, RD1E=RD2E=9, ALUControlE=001, PCE=0x100, ImmExtE=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0xF8; JumpE=1 → ALUResultM=PCPlus4E.
REQ-028 The bench SHALL cover: MulE=1, operands 0xFFFFFFFF and 3, RDE=7 → StallE=1 for 33 cycles with bubbles at MEM, then ALUResultM=0xFFFFFFFD, RDM=7, RegWriteM=1 on the 34th edge.
REQ-029 The bench SHALL cover: MulE started, with forward inputs changed during BUSY → product unchanged from latched operands.
REQ-030 The bench SHALL cover: rst=0 pulsed mid-clock at BUSY count 10 → outputs 0 and StallE=0 immediately, no product written, and the next ALU instruction completes in one cycle.

Source files
------------

// File: rtl/execute_cycle_cc.sv
// Execute stage: forwarding muxes, ALU, branch target, EX/MEM register, and a
// 32-cycle shift-add multiplier that stalls the front of the pipeline while busy.
module execute_cycle_cc (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ResultSrcE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic        MulE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [4:0]  RDE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] ResultW,
  output logic        RegWriteM,
  output logic        ResultSrcM,
  output logic        MemWriteM,
  output logic [4:0]  RDM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        StallE
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_rd;
  logic        r_rw;

  logic [31:0] w_srca;
  logic [31:0] w_wd;
  logic [31:0] w_srcb;
  logic [31:0] w_alu;
  logic        w_zero;
  logic        w_stall;
  logic        w_done;

  always_comb begin
    case (ForwardAE)
      2'b01:   w_srca = ResultW;
      2'b10:   w_srca = ALUResultM;
      default: w_srca = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   w_wd = ResultW;
      2'b10:   w_wd = ALUResultM;
      default: w_wd = RD2E;
    endcase
    w_srcb = ALUSrcE ? ImmExtE : w_wd;
  end

  always_comb begin
    case (ALUControlE)
      3'b000:  w_alu = w_srca + w_srcb;
      3'b001:  w_alu = w_srca - w_srcb;
      3'b010:  w_alu = w_srca & w_srcb;
      3'b011:  w_alu = w_srca | w_srcb;
      3'b101:  w_alu = ($signed(w_srca) < $signed(w_srcb)) ? 32'd1 : 32'd0;
      default: w_alu = 32'd0;
    endcase
  end

  assign w_zero    = (w_alu == 32'd0);
  assign PCTargetE = PCE + ImmExtE;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next-state logic; the counter is loaded with 32, so leaving BUSY when it
  // is about to hit zero gives exactly 32 BUSY cycles.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (MulE) w_state_next = S_BUSY;
      S_BUSY:  if (r_cnt == 6'd1) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs; stall is masked by reset so it drops immediately on rst=0
  always_comb begin
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = MulE & rst;
      S_BUSY:  w_stall = rst;
      S_DONE:  w_done  = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  assign StallE = w_stall;
  assign PCSrcE = ((BranchE & w_zero) | JumpE) & ~MulE & ~w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 6'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_rd     <= 5'd0;
      r_rw     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MulE) begin
            r_mcand  <= w_srca;
            r_mplier <= w_wd;
            r_acc    <= 32'd0;
            r_cnt    <= 6'd32;
            r_rd     <= RDE;
            r_rw     <= RegWriteE;
          end
        end
        S_BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      RDM        <= 5'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
    end else if (w_stall) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      RDM        <= 5'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
    end else if (w_done) begin
      RegWriteM  <= r_rw;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      RDM        <= r_rd;
      ALUResultM <= r_acc;
      WriteDataM <= 32'd0;
    end else begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      RDM        <= RDE;
      ALUResultM <= JumpE ? PCPlus4E : w_alu;
      WriteDataM <= w_wd;
    end
  end

endmodule

// File: tb/tb_execute_cycle_cc.sv
// Scoreboard bench for execute_cycle_cc: ALU path, forwarding, branch/jump,
// multi-cycle multiply with stall bubbles, and asynchronous abort.
module tb_execute_cycle_cc;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, MulE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [4:0]  RDE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        PCSrcE, StallE;
  logic [31:0] PCTargetE;

  typedef struct {
    logic        rw;
    logic        rs;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_alu    = 32'd0;

  always #5 clk = ~clk;

  execute_cycle_cc dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MulE(MulE),
    .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RDE(RDE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_bubble();
    exp_t e;
    e = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rw"}, RegWriteM, e.rw);
    chk({tag, "_rs"}, ResultSrcM, e.rs);
    chk({tag, "_mw"}, MemWriteM, e.mw);
    chk({tag, "_rd"}, RDM, e.rd);
    chk({tag, "_alu"}, ALUResultM, e.alu);
    chk({tag, "_wd"}, WriteDataM, e.wd);
    $display("txn %s: alu=%h rd=%0d rw=%0b wd=%h", tag, ALUResultM, RDM, RegWriteM, WriteDataM);
    m_alu = e.alu;
  endtask

  // Called just after a rising edge with the instruction already driven.
  task automatic step_alu(input string tag);
    logic [31:0] a, wd, b, r;
    exp_t        e;
    a  = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? m_alu : RD1E;
    wd = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? m_alu : RD2E;
    b  = ALUSrcE ? ImmExtE : wd;
    r  = alu_model(ALUControlE, a, b);
    #1;
    chk({tag, "_pcsrc"}, PCSrcE, (BranchE & (r == 32'd0)) | JumpE);
    chk({tag, "_pctgt"}, PCTargetE, PCE + ImmExtE);
    chk({tag, "_stall"}, StallE, 1'b0);
    e = '{RegWriteE, ResultSrcE, MemWriteE, RDE, JumpE ? PCPlus4E : r, wd};
    sb.push_back(e);
    @(posedge clk); #1;
    pop_compare(tag);
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd);
    ALUControlE = op; RD1E = a; RD2E = b; ImmExtE = imm; ALUSrcE = src; RDE = rd;
    RegWriteE = 1'b1; ResultSrcE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
    MulE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  // abort_busy < 0 runs to completion; otherwise reset is pulsed after that many BUSY cycles.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit perturb, input int abort_busy);
    exp_t        e;
    logic [31:0] prod;
    prod = a * b;
    set_alu(3'b000, a, b, 32'd0, 1'b0, rd);
    MulE = 1'b1; BranchE = 1'b1; JumpE = 1'b1;
    #1;
    chk({tag, "_start_stall"}, StallE, 1'b1);
    chk({tag, "_start_pcsrc"}, PCSrcE, 1'b0);
    push_bubble();
    @(posedge clk); #1;
    pop_compare({tag, "_start"});
    for (int i = 0; i < 32; i++) begin
      if (abort_busy == i) begin
        #2 rst = 1'b0;
        #1;
        chk({tag, "_abort_alu"}, ALUResultM, 32'd0);
        chk({tag, "_abort_rw"}, RegWriteM, 1'b0);
        chk({tag, "_abort_rd"}, RDM, 5'd0);
        chk({tag, "_abort_stall"}, StallE, 1'b0);
        MulE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
        #1 rst = 1'b1;
        m_alu = 32'd0;
        return;
      end
      if (perturb) begin
        RD1E = $urandom; RD2E = $urandom; ResultW = $urandom;
        ForwardAE = 2'b01; ForwardBE = 2'b10;
      end
      #1;
      chk({tag, "_busy_stall"}, StallE, 1'b1);
      push_bubble();
      @(posedge clk); #1;
      pop_compare({tag, "_busy"});
    end
    #1;
    chk({tag, "_done_stall"}, StallE, 1'b0);
    chk({tag, "_done_pcsrc"}, PCSrcE, 1'b0);
    e = '{1'b1, 1'b0, 1'b0, rd, prod, 32'd0};
    sb.push_back(e);
    @(posedge clk); #1;
    pop_compare({tag, "_done"});
    MulE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    set_alu(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    PCE = 32'd0; PCPlus4E = 32'd4; ResultW = 32'd0;
    MulE = 1'b1;
    #12;
    chk("rst_alu", ALUResultM, 32'd0);
    chk("rst_rw", RegWriteM, 1'b0);
    chk("rst_rd", RDM, 5'd0);
    chk("rst_stall", StallE, 1'b0);
    MulE = 1'b0;
    rst = 1'b1;

    set_alu(3'b000, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3);
    step_alu("add_imm");
    set_alu(3'b000, 32'h10, 32'd0, 32'd0, 1'b1, 5'd4);
    step_alu("pre_fwd");
    set_alu(3'b001, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0, 5'd5);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h4;
    step_alu("fwd_sub");
    set_alu(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0, 5'd6);
    MemWriteE = 1'b1; ResultSrcE = 1'b1;
    step_alu("and");
    set_alu(3'b011, 32'hF000_0000, 32'h0000_000F, 32'd0, 1'b0, 5'd7);
    step_alu("or");
    set_alu(3'b101, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 5'd8);
    step_alu("slt_neg");
    set_alu(3'b101, 32'd1, 32'hFFFF_FFFE, 32'd0, 1'b0, 5'd9);
    step_alu("slt_pos");
    set_alu(3'b100, 32'd3, 32'd4, 32'd0, 1'b0, 5'd10);
    step_alu("bad_op");
    set_alu(3'b000, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd11);
    step_alu("wrap");
    set_alu(3'b001, 32'd9, 32'd9, 32'hFFFF_FFF8, 1'b0, 5'd0);
    BranchE = 1'b1; RegWriteE = 1'b0; PCE = 32'h100;
    step_alu("beq_taken");
    set_alu(3'b001, 32'd9, 32'd8, 32'hFFFF_FFF8, 1'b0, 5'd0);
    BranchE = 1'b1; RegWriteE = 1'b0;
    step_alu("beq_not");
    set_alu(3'b000, 32'd1, 32'd2, 32'h40, 1'b0, 5'd1);
    JumpE = 1'b1; PCPlus4E = 32'h104;
    step_alu("jal");

    run_mul("mul", 32'hFFFF_FFFF, 32'd3, 5'd7, 1'b0, -1);
    set_alu(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2);
    step_alu("post_mul");
    run_mul("mul_pert", 32'h0001_2345, 32'h0000_6789, 5'd12, 1'b1, -1);
    run_mul("mul_abort", 32'd1000, 32'd1000, 5'd13, 1'b0, 22);
    set_alu(3'b000, 32'd20, 32'd22, 32'd0, 1'b0, 5'd14);
    step_alu("after_abort");
    set_alu(3'b011, 32'd1, 32'd2, 32'd0, 1'b0, 5'd15);
    step_alu("after_abort2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
